d_sram_like_bridge: RTL and testbench



---
 rtl/d_sram_like_bridge_pkg.sv | 38 +++
 rtl/d_sram_like_bridge_if.sv | 39 +++
 rtl/d_sram_like_bridge.sv | 134 +++++++++++++
 tb/tb_d_sram_like_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_sram_like_bridge_pkg.sv
// Shared types for the data-side SRAM-like bridge: FSM states,
// bus size codes and the wen -> (size, addr[1:0]) mapping.
package d_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] lo;
  } acc_fmt_t;

  // Reads and unrecognised patterns fall back to an aligned word.
  function automatic acc_fmt_t wen_fmt(input logic [3:0] wen);
    acc_fmt_t f;
    f.size = SIZE_WORD;
    f.lo   = 2'b00;
    unique case (wen)
      4'b0001: begin f.size = SIZE_BYTE; f.lo = 2'b00; end
      4'b0010: begin f.size = SIZE_BYTE; f.lo = 2'b01; end
      4'b0100: begin f.size = SIZE_BYTE; f.lo = 2'b10; end
      4'b1000: begin f.size = SIZE_BYTE; f.lo = 2'b11; end
      4'b0011: begin f.size = SIZE_HALF; f.lo = 2'b00; end
      4'b1100: begin f.size = SIZE_HALF; f.lo = 2'b10; end
      default: begin f.size = SIZE_WORD; f.lo = 2'b00; end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/d_sram_like_bridge_if.sv
// Split address/data handshake bus (req/addr_ok/data_ok).
// master: bridge side; slave: AXI/cache side.
interface d_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );

endinterface

// File: rtl/d_sram_like_bridge.sv
// CPU SRAM-style data port -> one-at-a-time split-handshake bus.
// Ports: clk, rst (async low), data_sram_* CPU side, d_stall, longest_stall, flush, bus (master).
module d_sram_like_bridge
  import d_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  input  logic              flush,
  d_sram_like_bridge_if.master bus
);

  state_e state_q;
  state_e state_d;

  logic              cancel_q;
  logic              cancel_d;
  logic              req_q;
  logic              req_d;
  logic              launch;
  logic              capture;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  acc_fmt_t          fmt;
  logic [ADDR_W-1:0] addr_d;

  assign fmt = wen_fmt(data_sram_wen);

  // Low two address bits come from the byte enables, not the CPU.
  assign addr_d = (data_sram_addr & ~ADDR_W'(3))
                | ADDR_W'(fmt.lo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    req_d    = req_q;
    launch   = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_sram_en && !flush) begin
          launch  = 1'b1;
          req_d   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_addr_ok) begin
          req_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (flush) cancel_d = 1'b1;
        // A flush landing with data_ok squashes this response too.
        if (bus.data_data_ok) begin
          if (cancel_q || flush) begin
            cancel_d = 1'b0;
            state_d  = IDLE;
          end else begin
            capture = !wr_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || !longest_stall) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (launch) begin
      wr_q    <= |data_sram_wen;
      size_q  <= fmt.size;
      addr_q  <= addr_d;
      wdata_q <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= bus.data_rdata;
    end
  end

  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  assign data_sram_rdata = rdata_q;

  // DONE releases the CPU; reset must never hold the pipeline.
  assign d_stall = rst & data_sram_en & (state_q != DONE);

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Bench for d_sram_like_bridge: CPU driver, bus responder,
// scoreboard queues for bus requests and CPU read data.
module tb_d_sram_like_bridge;
  import d_sram_like_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        longest_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] sram_rdata;
  logic        d_stall;

  always #5 clk = ~clk;

  d_sram_like_bridge_if bus ();

  d_sram_like_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .flush           (flush),
    .bus             (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          adly;
    int          ddly;
  } breq_t;

  breq_t       bq[$];
  logic [31:0] rq[$];
  logic [31:0] model_rd = '0;
  logic        resp_en = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_fmt(input logic [3:0] w);
    logic [1:0] lo;
    lo = 2'd0;
    if (w == 4'h3) return {SIZE_HALF, 2'd0};
    if (w == 4'hc) return {SIZE_HALF, 2'd2};
    if ($countones(w) == 1) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) lo = 2'(i);
      return {SIZE_BYTE, lo};
    end
    return {SIZE_WORD, 2'd0};
  endfunction

  function automatic breq_t mk_req(input logic [3:0] w,
                                   input logic [31:0] a,
                                   input logic [31:0] wd,
                                   input logic [31:0] rd,
                                   input int ad, input int dd);
    breq_t r;
    logic [3:0] f;
    f = exp_fmt(w);
    r.wr    = (w != 4'h0);
    r.size  = f[3:2];
    r.addr  = {a[31:2], f[1:0]};
    r.wdata = wd;
    r.rdata = rd;
    r.adly  = ad;
    r.ddly  = dd;
    return r;
  endfunction

  // Bus responder: accepts after adly cycles, answers ddly
  // cycles after the earliest legal data_ok slot.
  initial begin
    breq_t e;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    forever begin
      @(negedge clk);
      if (resp_en && bus.data_req === 1'b1) begin
        check("bus_q_len", bq.size(), 1);
        if (bq.size() != 0) begin
          e = bq.pop_front();
          check("bus_wr", bus.data_wr, e.wr);
          check("bus_size", bus.data_size, e.size);
          check("bus_addr", bus.data_addr, e.addr);
          check("bus_wdata", bus.data_wdata, e.wdata);
          for (int i = 0; i < e.adly; i++) begin
            @(negedge clk);
            check("req_hold", bus.data_req, 1'b1);
            check("addr_hold", bus.data_addr, e.addr);
          end
          bus.data_addr_ok = 1'b1;
          @(negedge clk);
          bus.data_addr_ok = 1'b0;
          check("req_drop", bus.data_req, 1'b0);
          repeat (e.ddly) @(negedge clk);
          bus.data_data_ok = 1'b1;
          bus.data_rdata   = e.rdata;
          @(negedge clk);
          bus.data_data_ok = 1'b0;
          bus.data_rdata   = $urandom;
        end
      end
    end
  end

  // Called at a falling edge; returns just after the falling
  // edge on which the access is seen complete.
  task automatic cpu_access(input logic [3:0] w,
                            input logic [31:0] a,
                            input logic [31:0] wd,
                            input logic [31:0] rd,
                            input int ad, input int dd,
                            input int stall_exp,
                            input int lstall);
    int n;
    int se;
    logic [31:0] exp_rd;
    en    = 1'b1;
    wen   = w;
    addr  = a;
    wdata = wd;
    bq.push_back(mk_req(w, a, wd, rd, ad, dd));
    if (w == 4'h0) model_rd = rd;
    rq.push_back(model_rd);
    se = (stall_exp < 0) ? 3 + ad + dd : stall_exp;
    n = 0;
    #1;
    while (d_stall && n < 100) begin
      @(negedge clk);
      n++;
      #1;
    end
    check("stall_cycles", n, se);
    exp_rd = rq.pop_front();
    check("sram_rdata", sram_rdata, exp_rd);
    if (lstall > 0) begin
      longest_stall = 1'b1;
      for (int i = 0; i < lstall; i++) begin
        bus.data_data_ok = (i == 0);
        bus.data_rdata   = 32'hFFFF_0000;
        @(negedge clk);
        #1;
        check("ls_dstall", d_stall, 1'b0);
        check("ls_no_req", bus.data_req, 1'b0);
        check("ls_rdata", sram_rdata, exp_rd);
      end
      bus.data_data_ok = 1'b0;
      longest_stall = 1'b0;
    end
    en = 1'b0;
  endtask

  // Read cancelled by a flush while waiting in DATA.
  task automatic flush_access(input logic [31:0] rd);
    en    = 1'b1;
    wen   = 4'h0;
    addr  = 32'h0000_6000;
    wdata = '0;
    bq.push_back(mk_req(4'h0, addr, '0, rd, 0, 2));
    #1;
    check("fl_stall", d_stall, 1'b1);
    @(negedge clk);
    #1;
    check("fl_req", bus.data_req, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] wtab [9];
    wtab = '{4'h0, 4'hf, 4'h3, 4'hc, 4'h1,
             4'h2, 4'h4, 4'h8, 4'h5};
    #1 rst = 1'b0;
    en = 1'b1;
    #12;
    check("rst_dstall", d_stall, 1'b0);
    check("rst_req", bus.data_req, 1'b0);
    check("rst_wr", bus.data_wr, 1'b0);
    check("rst_size", bus.data_size, 2'd0);
    check("rst_addr", bus.data_addr, 32'h0);
    check("rst_wdata", bus.data_wdata, 32'h0);
    check("rst_rdata", sram_rdata, 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    cpu_access(4'h0, 32'h0000_1004, 32'h0,
               32'hDEAD_BEEF, 0, 0, -1, 0);
    @(negedge clk);
    cpu_access(4'h4, 32'h0000_2001, 32'h00AB_0000,
               32'h1111_1111, 0, 0, -1, 0);
    @(negedge clk);
    cpu_access(4'h0, 32'h0000_3000, 32'h0,
               32'h1234_5678, 4, 0, -1, 5);
    @(negedge clk);
    cpu_access(4'hc, 32'h0000_4003, 32'hBEEF_0000,
               32'h0, 0, 1, -1, 0);
    @(negedge clk);
    cpu_access(4'hf, 32'h0000_5007, 32'hCAFE_F00D,
               32'h0, 1, 0, -1, 0);
    @(negedge clk);
    cpu_access(4'h5, 32'h0000_5103, 32'h00FF_00FF,
               32'h0, 0, 0, -1, 0);
    @(negedge clk);
    cpu_access(4'h0, 32'h0000_5200, 32'h0,
               32'hA5A5_5A5A, 0, 3, -1, 0);

    @(negedge clk);
    flush_access(32'h0BAD_F00D);
    cpu_access(4'h2, 32'h0000_6101, 32'h0000_CD00,
               32'h0, 0, 0, 5, 0);
    @(negedge clk);
    cpu_access(4'h0, 32'h0000_6200, 32'h0,
               32'h7777_8888, 0, 0, -1, 0);

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cpu_access(wtab[$urandom_range(0, 8)], $urandom,
                 $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 -1, $urandom_range(0, 2));
    end

    @(negedge clk);
    resp_en = 1'b0;
    en   = 1'b1;
    wen  = 4'h0;
    addr = 32'h0000_7000;
    @(negedge clk);
    #1;
    check("mid_req", bus.data_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_req_rst", bus.data_req, 1'b0);
    check("mid_dstall", d_stall, 1'b0);
    check("mid_rdata", sram_rdata, 32'h0);
    check("mid_addr", bus.data_addr, 32'h0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_hold_dstall", d_stall, 1'b0);
      check("rst_hold_req", bus.data_req, 1'b0);
    end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    resp_en = 1'b1;
    model_rd = '0;
    @(negedge clk);
    cpu_access(4'h0, 32'h0000_8008, 32'h0,
               32'h0102_0304, 2, 2, -1, 0);

    repeat (4) @(negedge clk);
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
